// File: rtl/mem_dma.sv
// mem_dma: block-copy initiator for the MU0 word memory.
// Reads one word at the current source address (RD), writes it at the
// current destination address (WR), and repeats until the word count is
// exhausted. Addresses wrap modulo 2^MAXDEPTH and the copy is always
// ascending.
//
// Optional feature macro: MEM_DMA_FILL_EN
//   When defined, adds the fill/fill_data inputs. A start with fill=1 writes
//   fill_data to len consecutive destination words, one word per cycle, and
//   never reads the memory.
//
// Every output is a register, so there is no combinational path from any
// input to any output.
module mem_dma #(
  parameter int MAXDEPTH = 12,
  parameter int MAXWIDTH = 16
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic                start,
  input  logic [MAXDEPTH-1:0] src,
  input  logic [MAXDEPTH-1:0] dst,
  input  logic [MAXDEPTH:0]   len,
`ifdef MEM_DMA_FILL_EN
  input  logic                fill,
  input  logic [MAXWIDTH-1:0] fill_data,
`endif
  output logic                busy,
  output logic                done,
  output logic                Wen,
  output logic                Ren,
  output logic [MAXDEPTH-1:0] address,
  output logic [MAXWIDTH-1:0] write_data,
  input  logic [MAXWIDTH-1:0] read_data
);

  // State encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;

  logic [1:0]          state;
  logic [MAXDEPTH-1:0] cur_src;
  logic [MAXDEPTH-1:0] cur_dst;
  logic [MAXDEPTH:0]   remaining;
  logic                fill_mode;

  // Fill request and word, tied off when the fill feature is not built
  logic                fill_req;
  logic [MAXWIDTH-1:0] fill_word;

`ifdef MEM_DMA_FILL_EN
  assign fill_req  = fill;
  assign fill_word = fill_data;
`else
  assign fill_req  = 1'b0;
  assign fill_word = '0;
`endif

  // Address step; the natural width overflow gives the wrap to address 0
  function automatic logic [MAXDEPTH-1:0] addr_inc(input logic [MAXDEPTH-1:0] a);
    return a + 1'b1;
  endfunction

  // True when the word now being written is the last one of the transfer
  function automatic logic is_last(input logic [MAXDEPTH:0] n);
    return n == {{MAXDEPTH{1'b0}}, 1'b1};
  endfunction

  // True for a zero-length request, which completes without touching memory
  function automatic logic is_empty(input logic [MAXDEPTH:0] n);
    return n == '0;
  endfunction

  // Transfer sequencer: owns the state, the working pointers and every output
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      cur_src    <= '0;
      cur_dst    <= '0;
      remaining  <= '0;
      fill_mode  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      Wen        <= 1'b0;
      Ren        <= 1'b0;
      address    <= '0;
      write_data <= '0;
    end else begin
      // done is a single-cycle pulse unless re-armed below
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_empty(len)) begin
              // Nothing to move: report completion without claiming the port
              done <= 1'b1;
            end else begin
              cur_src   <= src;
              cur_dst   <= dst;
              remaining <= len;
              busy      <= 1'b1;
              if (fill_req) begin
                // Fill goes straight to writing; the fill word is held in
                // write_data for the whole transfer
                fill_mode  <= 1'b1;
                state      <= WR;
                Wen        <= 1'b1;
                address    <= dst;
                write_data <= fill_word;
              end else begin
                fill_mode <= 1'b0;
                state     <= RD;
                Ren       <= 1'b1;
                address   <= src;
              end
            end
          end
        end

        RD: begin
          // The memory registered read_data on the falling edge; it is
          // stable here and becomes the word written in WR
          write_data <= read_data;
          Ren        <= 1'b0;
          Wen        <= 1'b1;
          address    <= cur_dst;
          state      <= WR;
        end

        WR: begin
          cur_src   <= addr_inc(cur_src);
          cur_dst   <= addr_inc(cur_dst);
          remaining <= remaining - 1'b1;
          if (is_last(remaining)) begin
            // address and write_data deliberately keep their last values
            state     <= IDLE;
            busy      <= 1'b0;
            Wen       <= 1'b0;
            fill_mode <= 1'b0;
            done      <= 1'b1;
          end else if (fill_mode) begin
            // Back-to-back writes: Wen stays high, only the address moves
            address <= addr_inc(cur_dst);
          end else begin
            state   <= RD;
            Wen     <= 1'b0;
            Ren     <= 1'b1;
            address <= addr_inc(cur_src);
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          Wen       <= 1'b0;
          Ren       <= 1'b0;
          fill_mode <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: self-checking bench for mem_dma.
// A word memory model answers the DMA on the falling edge. The expected
// memory image is a second array updated by a plain forward-copy loop.
// Table-driven copies, hand sequences for reset/ignored start/back-to-back,
// fill mode when MEM_DMA_FILL_EN is defined, then randomized copies.
module tb_mem_dma;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          Clk = 1'b0;
  logic          nReset;
  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          Wen;
  logic          Ren;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
`ifdef MEM_DMA_FILL_EN
  logic          fill;
  logic [DW-1:0] fill_data;
`endif

  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  int pass_n  = 0;
  int total_n = 0;

  typedef struct {
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    logic [AW:0]   n;
    int            exp_busy;
    int            exp_done_k;
    string         tag;
  } vec_t;

  mem_dma #(.MAXDEPTH(AW), .MAXWIDTH(DW)) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .start      (start),
    .src        (src),
    .dst        (dst),
    .len        (len),
`ifdef MEM_DMA_FILL_EN
    .fill       (fill),
    .fill_data  (fill_data),
`endif
    .busy       (busy),
    .done       (done),
    .Wen        (Wen),
    .Ren        (Ren),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data)
  );

  always #5 Clk = ~Clk;

  // Memory model: acts on the falling edge, read data registered
  always @(negedge Clk) begin
    if (Wen) mem[address] = write_data;
    if (Ren) read_data <= mem[address];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else pass_n++;
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Reference: ascending word-by-word copy with wrapping addresses
  task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] n);
    for (int i = 0; i < int'(n); i++)
      ref_mem[(int'(d) + i) % DEPTH] = ref_mem[(int'(s) + i) % DEPTH];
  endtask

  // One copy transfer, observed cycle by cycle after the start edge
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] n,
                          input int exp_busy, input int exp_done_k, input string tag);
    int busy_n = 0, done_n = 0, done_k = -1, rw_n = 0, addr_err = 0, ri = 0, wi = 0;
    @(negedge Clk);
    src = s; dst = d; len = n; start = 1'b1;
    model_copy(s, d, n);
    @(posedge Clk);
    for (int k = 0; k < exp_busy + 6; k++) begin
      @(negedge Clk);
      if (k == 0) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin done_n++; done_k = k; end
      if (Ren || Wen) rw_n++;
      if (Ren) begin
        if (address !== AW'(int'(s) + ri)) addr_err++;
        ri++;
      end
      if (Wen) begin
        if (address !== AW'(int'(d) + wi)) addr_err++;
        wi++;
      end
    end
    chk({tag, "_busy_cycles"}, busy_n, exp_busy);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_done_cycle"}, done_k, exp_done_k);
    chk({tag, "_mem_accesses"}, rw_n, exp_busy);
    chk({tag, "_reads"}, ri, int'(n));
    chk({tag, "_addr_seq"}, addr_err, 0);
    chk({tag, "_mem_image"}, mem_diffs(), 0);
  endtask

  initial begin
    vec_t          vecs [6];
    logic [DW-1:0] copy_exp [4];
    logic [AW-1:0] rs, rd;
    logic [AW:0]   rn;
    int            found, jdone, dseen;

    vecs[0] = '{s: 12'h010, d: 12'h200, n: 13'd4, exp_busy: 8,  exp_done_k: 8,  tag: "copy"};
    vecs[1] = '{s: 12'hFFE, d: 12'h100, n: 13'd3, exp_busy: 6,  exp_done_k: 6,  tag: "wrap_src"};
    vecs[2] = '{s: 12'h050, d: 12'h060, n: 13'd0, exp_busy: 0,  exp_done_k: 0,  tag: "len0"};
    vecs[3] = '{s: 12'h300, d: 12'h302, n: 13'd6, exp_busy: 12, exp_done_k: 12, tag: "overlap"};
    vecs[4] = '{s: 12'h020, d: 12'hFFD, n: 13'd5, exp_busy: 10, exp_done_k: 10, tag: "wrap_dst"};
    vecs[5] = '{s: 12'h7A0, d: 12'h7B0, n: 13'd1, exp_busy: 2,  exp_done_k: 2,  tag: "single"};
    copy_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[16'h010 + i]     = copy_exp[i];
      ref_mem[16'h010 + i] = copy_exp[i];
    end

    nReset = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
`ifdef MEM_DMA_FILL_EN
    fill = 1'b0; fill_data = '0;
`endif
    #1;
    chk("reset_outputs", {busy, done, Wen, Ren, address, write_data}, '0);
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    chk("idle_outputs", {busy, done, Wen, Ren}, '0);

    for (int v = 0; v < 6; v++)
      run_copy(vecs[v].s, vecs[v].d, vecs[v].n, vecs[v].exp_busy, vecs[v].exp_done_k, vecs[v].tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("copy_word_%0d", i), mem[12'h200 + i], copy_exp[i]);

    // Reset during the second WR of a len=4 copy, with an ignored start
    @(negedge Clk);
    src = 12'h020; dst = 12'h400; len = 13'd4; start = 1'b1;
    @(posedge Clk);
    @(negedge Clk); start = 1'b0;
    @(negedge Clk); start = 1'b1; src = 12'h030; dst = 12'h500; len = 13'd1;
    @(negedge Clk); start = 1'b0;
    @(posedge Clk); #2;
    chk("pre_reset_in_wr", {busy, Wen, address}, {1'b1, 1'b1, 12'h401});
    nReset = 1'b0;
    #1;
    chk("midreset_outputs", {busy, done, Wen, Ren, address, write_data}, '0);
    dseen = 0;
    repeat (3) begin
      @(negedge Clk);
      if (done) dseen++;
    end
    nReset = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      if (done) dseen++;
    end
    chk("midreset_no_done", dseen, 0);
    ref_mem[12'h400] = ref_mem[12'h020];
    chk("midreset_mem_image", mem_diffs(), 0);
    run_copy(12'h040, 12'h410, 13'd2, 4, 4, "after_reset");

    // Back-to-back: second start presented in the done cycle
    @(negedge Clk);
    src = 12'h600; dst = 12'h640; len = 13'd2; start = 1'b1;
    model_copy(12'h600, 12'h640, 13'd2);
    @(posedge Clk);
    @(negedge Clk); start = 1'b0;
    found = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      if (done) begin
        found = 1;
        src = 12'h610; dst = 12'h650; len = 13'd2; start = 1'b1;
        model_copy(12'h610, 12'h650, 13'd2);
      end else begin
        @(negedge Clk);
      end
    end
    chk("b2b_first_done", found, 1);
    if (found == 1) begin
      @(negedge Clk); start = 1'b0;
      chk("b2b_second_accept", {busy, Ren, address}, {1'b1, 1'b1, 12'h610});
      jdone = -1;
      for (int j = 1; j < 10; j++) begin
        @(negedge Clk);
        if (done && jdone < 0) jdone = j;
      end
      chk("b2b_second_done_cycle", jdone, 4);
      chk("b2b_mem_image", mem_diffs(), 0);
    end

`ifdef MEM_DMA_FILL_EN
    begin
      int fb = 0, fr = 0, fk = -1;
      @(negedge Clk);
      fill = 1'b1; fill_data = 16'hBEEF; src = 12'h123; dst = 12'h300; len = 13'd5; start = 1'b1;
      for (int i = 0; i < 5; i++) ref_mem[12'h300 + i] = 16'hBEEF;
      @(posedge Clk);
      for (int k = 0; k < 12; k++) begin
        @(negedge Clk);
        if (k == 0) begin start = 1'b0; fill = 1'b0; end
        if (busy) fb++;
        if (Ren) fr++;
        if (done && fk < 0) fk = k;
      end
      chk("fill_busy_cycles", fb, 5);
      chk("fill_no_reads", fr, 0);
      chk("fill_done_cycle", fk, 5);
      chk("fill_mem_image", mem_diffs(), 0);
      for (int i = 0; i < 5; i++) chk($sformatf("fill_word_%0d", i), mem[12'h300 + i], 16'hBEEF);
    end
`endif

    // Randomized copies against the reference image
    for (int r = 0; r < 8; r++) begin
      rs = AW'($urandom_range(DEPTH - 1, 0));
      rd = AW'($urandom_range(DEPTH - 1, 0));
      rn = (AW + 1)'($urandom_range(24, 1));
      run_copy(rs, rd, rn, 2 * int'(rn), 2 * int'(rn), $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Block-copy initiator for the MU0 memory. Given source address, destination address and length, it reads each word from the memory and writes it back at the destination, one word at a time, by driving the memory's `Wen`/`Ren`/`address`/`write_data` interface and sampling `read_data`. It sits between the control logic, such as the CPU or debug/loader logic, and the word memory, and shares that memory's port with the CPU through an external mux while `busy` is high.

## Interface
- `MAXDEPTH`, 12: address width in bits; memory holds 2^MAXDEPTH words.
- `MAXWIDTH`, 16: data word width in bits.
- `Clk`  in  1  clock; block state changes on the rising edge only.
- `nReset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a copy; sampled on a rising edge when `busy`=0.
- `src`  in  MAXDEPTH  first source word address, latched on start.
- `dst`  in  MAXDEPTH  first destination word address, latched on start.
- `len`  in  MAXDEPTH+1  word count, latched on start; 0 to 2^MAXDEPTH.
- `busy`  out  1  transfer in progress; block owns the memory port.
- `done`  out  1  one-cycle pulse at transfer completion.
- `Wen`  out  1  memory write enable.
- `Ren`  out  1  memory read enable.
- `address`  out  MAXDEPTH  memory word address.
- `write_data`  out  MAXWIDTH  memory write data.
- `read_data`  in  MAXWIDTH  memory read data. Memory registers it on the falling edge of `Clk` when `Ren`=1.

## Operation
- States:
  - IDLE: start state.
  - RD: read phase.
  - WR: write phase.
- All outputs are registers; there are no combinational paths from inputs to outputs.
- IDLE:
  - `start`=1 and `len`>0: latch `src`, `dst`, `len`, then go to RD.
  - `start`=1 and `len`=0: stay in IDLE and pulse `done` on the next cycle. No memory access occurs.
- RD:
  - Outputs: `Ren`=1, `Wen`=0, `address`=current source, `busy`=1.
  - On the next edge: capture `read_data` into the data register, then go to WR.
- WR:
  - Outputs: `Wen`=1, `Ren`=0, `address`=current destination, `write_data`=captured word, `busy`=1.
  - On the next edge: increment source and destination, decrement remaining count.
  - If the remaining count reaches 0: go to IDLE and set `done`=1 for one cycle. Otherwise go to RD.
- Addresses increment modulo 2^MAXDEPTH, so 0xFFF+1 = 0x000 and the transfer continues.
- Copy order is always ascending. If the regions overlap with `dst`>`src`, the result is the forward-copy result by definition.
- `start` while `busy`=1 is ignored and not queued.
- `start` in the same cycle as `done`=1 is accepted, because `busy` is already 0.
- Reset values of all outputs are 0: `busy`, `done`, `Wen`, `Ren`, `address`, `write_data`. State goes to IDLE.
- Reset mid-transfer: abort immediately, with no `done` pulse.

## Timing
- Memory handshake:
  - The block drives `Ren`/`Wen`/`address` from the rising edge.
  - The memory acts on the following falling edge.
  - `read_data` is stable at the next rising edge, where the block samples it.
- Per word: 2 cycles, RD then WR.
- Let edge E be the edge that samples `start`. Then:
  - `busy` is high from E through E+2·len.
  - `done` is high in the cycle after E+2·len.
- `len`=0: `done` is high in the cycle after E, and `busy` stays 0.
- Outside RD and WR, `Ren`=`Wen`=0. `address` and `write_data` hold their last values.

## Configuration
- `MEM_DMA_FILL_EN`:
  - Defined:
    - Adds inputs `fill` (1 bit) and `fill_data` (MAXWIDTH), latched on start.
    - With `fill`=1 the block skips RD and writes `fill_data` to `len` words starting at `dst`, one word per cycle.
    - In fill mode `busy` spans len cycles, and `src` is ignored.
  - Undefined: the ports are absent and only copy mode exists.

## Test plan
- Copy:
  - Preload mem[0x010..0x013]=0x1111,0x2222,0x3333,0x4444.
  - Start with src=0x010, dst=0x200, len=4.
  - Expect mem[0x200..0x203] to match the source.
  - Expect `busy` high for 8 cycles and exactly one `done` pulse.
- Wrap:
  - Start with src=0xFFE, dst=0x100, len=3.
  - Expect reads at 0xFFE, 0xFFF, 0x000 and writes at 0x100–0x102.
- `len`=0:
  - Expect `done` the cycle after start.
  - Expect `busy`, `Wen` and `Ren` never to rise.
- Reset and ignored start:
  - Assert `nReset`=0 during the second WR of a len=4 copy.
  - Expect all outputs 0 immediately, no `done`, and only 1 destination word written.
  - A `start` pulsed while `busy`=1 has no effect.
- Back-to-back:
  - Assert `start` in the `done` cycle.
  - Expect the second transfer accepted with no idle gap.
- Fill (`MEM_DMA_FILL_EN`):
  - fill=1, fill_data=0xBEEF, dst=0x300, len=5.
  - Expect mem[0x300..0x304]=0xBEEF, `busy` high for 5 cycles, and `Ren` never high.
